// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: mode-machine encoding and
// button synchronizer depth.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CONFIG = 2'b01,
    ST_RUN    = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizer, stability counter and a one-cycle
// pulse on each accepted press (releases are not reported).
module btn_debounce
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   level_reg;
  logic                   level_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg       <= '0;
      cnt_reg        <= '0;
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], raw};
      level_prev_reg <= level_reg;
      // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
      if (sync_reg[SYNC_STAGES-1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= ~level_reg;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = level_reg & ~level_prev_reg;

endmodule

// File: rtl/counter_sequencer.sv
// Single-clock control for the modulo counter: two debounced buttons drive
// an idle/configure/run/hold machine that steps a counter with a wrap pulse.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEFAULT_MOD     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] TERM_RESET = WIDTH'(DEFAULT_MOD - 1);

  // Bit 0 is the step button, bit 1 the mode button.
  logic [1:0] raw_btn;
  logic [1:0] press_vec;
  logic [1:0] level_unused;

  assign raw_btn = {btn_mode, btn_step};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_btn[gi]),
        .level(level_unused[gi]),
        .press(press_vec[gi])
      );
    end
  endgenerate

  logic step_press;
  logic mode_press;
  assign step_press = press_vec[0];
  assign mode_press = press_vec[1];

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] term_reg, term_next;
  logic             wrap_reg, wrap_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      term_reg  <= TERM_RESET;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      term_reg  <= term_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    term_next  = term_reg;
    wrap_next  = 1'b0;
    // Simultaneous presses act as an abort from any state.
    if (step_press && mode_press) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          count_next = '0;
          if (mode_press) state_next = ST_CONFIG;
        end
        ST_CONFIG: begin
          count_next = '0;
          if (mode_press) begin
            state_next = ST_RUN;
            // A modulus of 0 or 1 selects the full 2^WIDTH range.
            term_next  = (mod_in <= WIDTH'(1)) ? '1 : mod_in - WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (mode_press) begin
            state_next = ST_HOLD;
          end else if (step_press) begin
            if (count_reg == term_reg) begin
              count_next = '0;
              wrap_next  = 1'b1;
            end else begin
              count_next = count_reg + WIDTH'(1);
            end
          end
        end
        ST_HOLD: begin
          if (mode_press) state_next = ST_RUN;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;
  assign state = state_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: each stimulus pushes its expected outputs and due edge into
// a scoreboard queue; a monitor checks them and flags any unscheduled change.
module tb_counter_sequencer;

  localparam int D = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_CONFIG = 2'd1, S_RUN = 2'd2, S_HOLD = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_step;
  logic       btn_mode;
  logic [2:0] mod_in;
  logic [2:0] count;
  logic       wrap;
  logic [1:0] state;

  counter_sequencer #(
    .WIDTH(3),
    .DEBOUNCE_CYCLES(D),
    .DEFAULT_MOD(6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_step(btn_step),
    .btn_mode(btn_mode),
    .mod_in  (mod_in),
    .count   (count),
    .wrap    (wrap),
    .state   (state)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         tgt;
    logic [1:0] st;
    logic [2:0] cnt;
    logic       wr;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  bit   armed = 1'b0;
  logic [1:0] last_st;
  logic [2:0] last_cnt;
  logic       last_wr;

  function automatic void push(int tgt, logic [1:0] st, logic [2:0] c, logic w, string nm);
    exp_t x;
    x.tgt  = tgt;
    x.st   = st;
    x.cnt  = c;
    x.wr   = w;
    x.name = nm;
    sb.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tgt == edge_cnt) begin
      cur = sb.pop_front();
      total++;
      if (state !== cur.st || count !== cur.cnt || wrap !== cur.wr) begin
        bad++;
        $display("FAIL %s @edge %0d: got state=%0d count=%0d wrap=%0d, want state=%0d count=%0d wrap=%0d",
                 cur.name, edge_cnt, state, count, wrap, cur.st, cur.cnt, cur.wr);
      end else begin
        $display("ok   %s @edge %0d: state=%0d count=%0d wrap=%0d", cur.name, edge_cnt, state, count, wrap);
      end
      last_st  = cur.st;
      last_cnt = cur.cnt;
      last_wr  = cur.wr;
      armed    = 1'b1;
    end else if (armed && (state !== last_st || count !== last_cnt || wrap !== last_wr)) begin
      total++;
      bad++;
      $display("FAIL unexpected_change @edge %0d: got state=%0d count=%0d wrap=%0d, want state=%0d count=%0d wrap=%0d",
               edge_cnt, state, count, wrap, last_st, last_cnt, last_wr);
      last_st  = state;
      last_cnt = count;
      last_wr  = wrap;
    end
  end

  // Holds the chosen button(s) high for 'hold' sampled edges, then releases
  // long enough for the accepted level to fall before the next press.
  task automatic press_btn(input bit is_mode, input bit both, input int hold,
                           input logic [1:0] st, input logic [2:0] c, input logic w,
                           input string nm);
    int e;
    @(negedge clk);
    e = edge_cnt;
    if (both) begin
      btn_step = 1'b1;
      btn_mode = 1'b1;
    end else if (is_mode) begin
      btn_mode = 1'b1;
    end else begin
      btn_step = 1'b1;
    end
    push(e + D + 3, st, c, w, nm);
    if (w) push(e + D + 4, st, c, 1'b0, {nm, "_wrap_end"});
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  logic [2:0] seq5 [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
  logic [2:0] mods [2] = '{3'd0, 3'd1};

  initial begin
    btn_step = 1'b0;
    btn_mode = 1'b0;
    mod_in   = 3'd0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    push(edge_cnt + 1, S_IDLE, 3'd0, 1'b0, "reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) press_btn(1'b0, 1'b0, D + 3, S_IDLE, 3'd0, 1'b0, "idle_step");

    mod_in = 3'd5;
    press_btn(1'b1, 1'b0, D + 3, S_CONFIG, 3'd0, 1'b0, "to_config");
    press_btn(1'b1, 1'b0, D + 3, S_RUN, 3'd0, 1'b0, "to_run_mod5");
    mod_in = 3'd7;
    for (int i = 0; i < 6; i++) press_btn(1'b0, 1'b0, D + 3, S_RUN, seq5[i], (i == 4), "mod5_step");

    press_btn(1'b0, 1'b0, D - 1, S_RUN, 3'd1, 1'b0, "glitch");
    press_btn(1'b0, 1'b0, D + 3, S_RUN, 3'd2, 1'b0, "step_after_glitch");
    press_btn(1'b0, 1'b1, D + 3, S_IDLE, 3'd0, 1'b0, "both_abort");

    for (int m = 0; m < 2; m++) begin
      mod_in = mods[m];
      press_btn(1'b1, 1'b0, D + 3, S_CONFIG, 3'd0, 1'b0, "to_config_full");
      press_btn(1'b1, 1'b0, D + 3, S_RUN, 3'd0, 1'b0, "to_run_full");
      for (int i = 0; i < 8; i++)
        press_btn(1'b0, 1'b0, D + 3, S_RUN, 3'(i + 1), (i == 7), "full_step");
      if (m == 0) press_btn(1'b0, 1'b1, D + 3, S_IDLE, 3'd0, 1'b0, "both_abort_full");
    end

    for (int i = 0; i < 3; i++) press_btn(1'b0, 1'b0, D + 3, S_RUN, 3'(i + 1), 1'b0, "run_to_3");
    press_btn(1'b1, 1'b0, D + 3, S_HOLD, 3'd3, 1'b0, "to_hold");
    for (int i = 0; i < 2; i++) press_btn(1'b0, 1'b0, D + 3, S_HOLD, 3'd3, 1'b0, "hold_step");
    press_btn(1'b1, 1'b0, D + 3, S_RUN, 3'd3, 1'b0, "hold_to_run");
    press_btn(1'b0, 1'b0, D + 3, S_RUN, 3'd4, 1'b0, "resume_step");

    @(negedge clk);
    reset = 1'b1;
    push(edge_cnt + 1, S_IDLE, 3'd0, 1'b0, "reset_mid_run");
    @(negedge clk);
    reset = 1'b0;
    press_btn(1'b0, 1'b0, D + 3, S_IDLE, 3'd0, 1'b0, "idle_after_reset");

    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
